pipelined_control_unit: RTL and testbench
=========================================

// Module: pipelined_control_unit
// PURPOSE
//  Parametrised successor to the single-cycle control decoder. Decodes tipo/op/Inm into a
//  control bundle and carries it through registered EX, MEM and WB stages with valid bits.
//  Supports stall and flush. Adds a channel sequencer: a burst memory access is replayed
//  for NUM_CHANNELS beats in MEM, with RGB stepping 0..N-1. Sits between fetch/ID and the datapath.
// PARAMETERS
//  TIPO_W        2   width of tipo field
//  OP_W          2   width of op field (>=2)
//  ALUCTRL_W     3   width of ALUControl
//  NUM_CHANNELS  3   memory channels per burst (>=1)
//  CH_W          $clog2(NUM_CHANNELS) min 1; width of RGB
// PORTS
//  clk            in   1          clock
//  rst            in   1          async reset, active-high
//  valid_in       in   1          ID-stage instruction present
//  tipo           in   TIPO_W     instruction type
//  op             in   OP_W       operation
//  Inm            in   1          immediate bit
//  stall_in       in   1          downstream stall: freeze whole pipe
//  flush_in       in   1          branch taken in EX: kill EX and the ID capture
//  ready_out      out  1          = !(stall_in | burst_busy); ID is accepted when valid_in & ready_out
//  ex_ALUSrc      out  1          EX: ALU operand select
//  ex_ImmSrc      out  2          EX: immediate format
//  ex_ALUControl  out  ALUCTRL_W  EX: ALU operation
//  ex_Branch      out  1          EX: conditional branch (gated by EX valid)
//  ex_Jump        out  1          EX: jump (gated by EX valid)
//  mem_MemWrite   out  1          MEM: store strobe, per beat
//  mem_RGB        out  CH_W       MEM: channel index of the current beat
//  wb_RegWrite    out  1          WB: register write (gated by WB valid)
//  wb_ResultSrc   out  1          WB: 0 = ALU, 1 = memory
// BEHAVIOUR
//  Decode (combinational):
//   - tipo 00 DP: RegWrite=1, ALUSrc=Inm, ImmSrc=00, ALUControl={0,op[1:0]}.
//   - tipo 01 MEM: ALUSrc=1, ImmSrc=01, ALUControl=000, MemWrite=op[0],
//     RegWrite=ResultSrc=~op[0], burst=op[1].
//   - tipo 10 BR: Branch=1, ALUSrc=Inm, ImmSrc=10, ALUControl=001.
//   - tipo 11 JMP, op==0: Jump=1, ImmSrc=10.
//   - Any other tipo 11 encoding is a NOP: all-zero bundle, captured as a bubble.
//  Reset (async): all stage valids=0, FSM=IDLE, beat=0. Every ex_/mem_/wb_ output is 0.
//  Latency: instruction accepted at edge N drives ex_* after N, mem_* after N+1, wb_* after N+2.
//  Every output is bundle & stage_valid; bubbles drive 0.
//  hold = stall_in | burst_busy. Priority rules:
//   - stall_in=1: EX, MEM, WB and the beat counter all keep their values.
//   - burst_busy=1 and stall_in=0: EX and MEM keep their values; WB takes a bubble;
//     the beat counter increments.
//   - flush_in=1 (highest priority, applies even while holding): next EX valid=0 and no ID
//     capture. MEM and WB are unaffected.
//  Sequencer FSM: IDLE, BURST.
//   - IDLE->BURST: a valid burst instruction enters MEM. beat=0.
//   - BURST: mem_RGB=beat, mem_MemWrite=MemWrite on every beat.
//     burst_busy = (beat != NUM_CHANNELS-1).
//   - Final beat with stall_in=0: the instruction advances to WB once, with a single
//     RegWrite for a load. FSM goes to IDLE, or restarts BURST at beat 0 if the next MEM
//     instruction is also a burst.
//   - Non-burst memory access: single beat, mem_RGB=0.
//   - NUM_CHANNELS=1: a burst behaves exactly like a non-burst access (burst_busy never asserted).
//  Reset mid-burst aborts the burst; no partial WB.
// STRUCTURE
//  control_pkg: ctrl_t struct (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump,
//   ALUControl, burst), tipo enum (T_DP, T_MEM, T_BR, T_JMP), ALU code localparams, seq_state_t.
//  Sub-module ctrl_decoder: pure combinational tipo/op/Inm -> ctrl_t.
//  Top module holds the stage registers, hold/flush logic and the sequencer.
// TESTING
//  1. Reset with stall_in=0 -> all outputs 0 and ready_out=1. Then DP op=01 Inm=1 ->
//     next cycle ex_ALUControl=001, ex_ALUSrc=1; two cycles after that, wb_RegWrite=1.
//  2. Store burst (tipo=01, op=11), NUM_CHANNELS=3 -> mem_RGB 0,1,2 on consecutive cycles,
//     mem_MemWrite=1 on all three, ready_out=0 for 2 cycles, one WB slot.
//  3. stall_in=1 for 2 cycles during beat 1 -> mem_RGB holds 1 for 3 cycles, then goes to 2.
//     No beat is lost.
//  4. Branch in EX with flush_in=1 and valid_in=1 -> next cycle ex_Branch=0 and EX is a bubble.
//     The instruction already in MEM still reaches WB.
//  5. Two back-to-back load bursts -> mem_RGB 0,1,2,0,1,2; wb_RegWrite pulses exactly twice.
//  6. rst asserted at beat 1 -> outputs 0 immediately (async). After release FSM=IDLE,
//     mem_RGB=0, no WB pulse.

Source files
------------

// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Package     : control_pkg
// Description : Shared types for the pipelined control unit: the decoded
//               control bundle, instruction type encoding, ALU operation
//               codes and the memory-channel sequencer state.
// Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

   // Width of the ALU operation code carried inside the control bundle.
   // The top level resizes it to its ALUCTRL_W output.
   localparam int c_ALU_W = 3;

   localparam logic [c_ALU_W-1:0] c_ALU_ADD = 3'b000;
   localparam logic [c_ALU_W-1:0] c_ALU_SUB = 3'b001;

   typedef enum logic [1:0] {
      T_DP  = 2'b00,
      T_MEM = 2'b01,
      T_BR  = 2'b10,
      T_JMP = 2'b11
   } tipo_t;

   typedef struct packed {
      logic               RegWrite;
      logic [1:0]         ImmSrc;
      logic               ALUSrc;
      logic               MemWrite;
      logic               ResultSrc;
      logic               Branch;
      logic               Jump;
      logic [c_ALU_W-1:0] ALUControl;
      logic               burst;
   } ctrl_t;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } seq_state_t;

endpackage : control_pkg
`default_nettype wire

// File: rtl/ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decoder
// Description : Pure combinational instruction decoder, tipo/op/Inm to the
//               control bundle. Unused encodings produce an all-zero bundle
//               and raise nop so the pipeline captures a bubble.
// Ports       : tipo [TIPO_W] in  - instruction type
//               op   [OP_W]   in  - operation
//               Inm           in  - immediate bit
//               ctrl          out - decoded control bundle
//               nop           out - encoding is a no-operation
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decoder
   import control_pkg::*;
#(
   parameter int TIPO_W = 2,
   parameter int OP_W   = 2
)(
   input  logic [TIPO_W-1:0] tipo,
   input  logic [OP_W-1:0]   op,
   input  logic              Inm,
   output ctrl_t             ctrl,
   output logic              nop
);

   // Any set bit above the two type bits is not a defined type.
   logic [TIPO_W-1:0] w_tipo_hi;
   tipo_t             w_tipo;

   assign w_tipo_hi = tipo >> 2;
   assign w_tipo    = tipo_t'(tipo[1:0]);

   always_comb begin
      ctrl = '0;
      nop  = 1'b0;
      if (w_tipo_hi != '0) begin
         nop = 1'b1;
      end else begin
         case (w_tipo)
            T_DP: begin
               ctrl.RegWrite   = 1'b1;
               ctrl.ALUSrc     = Inm;
               ctrl.ImmSrc     = 2'b00;
               ctrl.ALUControl = {1'b0, op[1:0]};
            end
            T_MEM: begin
               ctrl.ALUSrc     = 1'b1;
               ctrl.ImmSrc     = 2'b01;
               ctrl.ALUControl = c_ALU_ADD;
               ctrl.MemWrite   = op[0];
               ctrl.RegWrite   = ~op[0];
               ctrl.ResultSrc  = ~op[0];
               ctrl.burst      = op[1];
            end
            T_BR: begin
               ctrl.Branch     = 1'b1;
               ctrl.ALUSrc     = Inm;
               ctrl.ImmSrc     = 2'b10;
               ctrl.ALUControl = c_ALU_SUB;
            end
            default: begin
               if (op == '0) begin
                  ctrl.Jump   = 1'b1;
                  ctrl.ImmSrc = 2'b10;
               end else begin
                  nop = 1'b1;
               end
            end
         endcase
      end
   end

endmodule : ctrl_decoder
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_control_unit
// Description : Decodes ID-stage instructions and carries the control bundle
//               through registered EX, MEM and WB stages with valid bits.
//               Burst memory accesses are replayed for NUM_CHANNELS beats in
//               MEM with mem_RGB stepping through the channels.
// Ports       : clk, rst (async, active-high)
//               valid_in, tipo, op, Inm     - ID-stage instruction
//               stall_in, flush_in          - pipeline control
//               ready_out                   - ID accepted when valid_in & ready_out
//               ex_*  - EX stage controls   (ALUSrc, ImmSrc, ALUControl, Branch, Jump)
//               mem_* - MEM stage controls  (MemWrite, RGB)
//               wb_*  - WB stage controls   (RegWrite, ResultSrc)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_control_unit
   import control_pkg::*;
#(
   parameter int TIPO_W       = 2,
   parameter int OP_W         = 2,
   parameter int ALUCTRL_W    = 3,
   parameter int NUM_CHANNELS = 3,
   parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [TIPO_W-1:0]    tipo,
   input  logic [OP_W-1:0]      op,
   input  logic                 Inm,
   input  logic                 stall_in,
   input  logic                 flush_in,
   output logic                 ready_out,
   output logic                 ex_ALUSrc,
   output logic [1:0]           ex_ImmSrc,
   output logic [ALUCTRL_W-1:0] ex_ALUControl,
   output logic                 ex_Branch,
   output logic                 ex_Jump,
   output logic                 mem_MemWrite,
   output logic [CH_W-1:0]      mem_RGB,
   output logic                 wb_RegWrite,
   output logic                 wb_ResultSrc
);

   localparam logic [CH_W-1:0] c_LAST_BEAT = CH_W'(NUM_CHANNELS - 1);
   // With a single channel a burst is an ordinary access; never sequence it.
   localparam bit              c_MULTI     = (NUM_CHANNELS > 1);

   ctrl_t w_dec;
   logic  w_nop;
   logic  w_burst_busy;
   logic  w_hold;

   // EX keeps the full bundle; later stages keep only the fields they use.
   logic       r_ex_v;
   ctrl_t      r_ex;
   logic       r_mem_v;
   logic       r_mem_memwrite;
   logic       r_mem_regwrite;
   logic       r_mem_resultsrc;
   logic       r_wb_v;
   logic       r_wb_regwrite;
   logic       r_wb_resultsrc;
   seq_state_t r_state;
   logic [CH_W-1:0] r_beat;

   ctrl_decoder #(
      .TIPO_W (TIPO_W),
      .OP_W   (OP_W)
   ) u_decoder (
      .tipo (tipo),
      .op   (op),
      .Inm  (Inm),
      .ctrl (w_dec),
      .nop  (w_nop)
   );

   assign w_burst_busy = (r_state == S_BURST) && (r_beat != c_LAST_BEAT);
   assign w_hold       = stall_in | w_burst_busy;
   assign ready_out    = ~w_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_v          <= 1'b0;
         r_ex            <= '0;
         r_mem_v         <= 1'b0;
         r_mem_memwrite  <= 1'b0;
         r_mem_regwrite  <= 1'b0;
         r_mem_resultsrc <= 1'b0;
         r_wb_v          <= 1'b0;
         r_wb_regwrite   <= 1'b0;
         r_wb_resultsrc  <= 1'b0;
         r_state         <= S_IDLE;
         r_beat          <= '0;
      end else begin
         // EX: flush wins over everything, including a held EX instruction.
         if (flush_in) begin
            r_ex_v <= 1'b0;
         end else if (!w_hold) begin
            r_ex_v <= valid_in & ~w_nop;
            r_ex   <= w_dec;
         end

         if (!w_hold) begin
            // Whole pipe advances; the sequencer restarts from what enters MEM.
            r_mem_v         <= r_ex_v;
            r_mem_memwrite  <= r_ex.MemWrite;
            r_mem_regwrite  <= r_ex.RegWrite;
            r_mem_resultsrc <= r_ex.ResultSrc;
            r_wb_v          <= r_mem_v;
            r_wb_regwrite   <= r_mem_regwrite;
            r_wb_resultsrc  <= r_mem_resultsrc;
            r_beat          <= '0;
            if (c_MULTI && r_ex_v && r_ex.burst) begin
               r_state <= S_BURST;
            end else begin
               r_state <= S_IDLE;
            end
         end else if (!stall_in) begin
            // Burst replay: MEM repeats, WB sees a bubble until the last beat.
            r_wb_v <= 1'b0;
            r_beat <= r_beat + CH_W'(1);
         end
      end
   end

   assign ex_ALUSrc     = r_ex_v & r_ex.ALUSrc;
   assign ex_ImmSrc     = {2{r_ex_v}} & r_ex.ImmSrc;
   assign ex_ALUControl = ALUCTRL_W'({c_ALU_W{r_ex_v}} & r_ex.ALUControl);
   assign ex_Branch     = r_ex_v & r_ex.Branch;
   assign ex_Jump       = r_ex_v & r_ex.Jump;
   assign mem_MemWrite  = r_mem_v & r_mem_memwrite;
   assign mem_RGB       = r_mem_v ? r_beat : '0;
   assign wb_RegWrite   = r_wb_v & r_wb_regwrite;
   assign wb_ResultSrc  = r_wb_v & r_wb_resultsrc;

endmodule : pipelined_control_unit
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_control_unit
// Description : Directed self-checking bench for pipelined_control_unit with
//               three memory channels. Inputs change and outputs are sampled
//               1 time unit after each rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       valid_in = 1'b0;
   logic [1:0] tipo = 2'b00;
   logic [1:0] op = 2'b00;
   logic       Inm = 1'b0;
   logic       stall_in = 1'b0;
   logic       flush_in = 1'b0;
   logic       ready_out;
   logic       ex_ALUSrc;
   logic [1:0] ex_ImmSrc;
   logic [2:0] ex_ALUControl;
   logic       ex_Branch;
   logic       ex_Jump;
   logic       mem_MemWrite;
   logic [1:0] mem_RGB;
   logic       wb_RegWrite;
   logic       wb_ResultSrc;

   int n_checks = 0;
   int n_pass   = 0;
   int wb_pulses;

   pipelined_control_unit #(
      .TIPO_W       (2),
      .OP_W         (2),
      .ALUCTRL_W    (3),
      .NUM_CHANNELS (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_in      (valid_in),
      .tipo          (tipo),
      .op            (op),
      .Inm           (Inm),
      .stall_in      (stall_in),
      .flush_in      (flush_in),
      .ready_out     (ready_out),
      .ex_ALUSrc     (ex_ALUSrc),
      .ex_ImmSrc     (ex_ImmSrc),
      .ex_ALUControl (ex_ALUControl),
      .ex_Branch     (ex_Branch),
      .ex_Jump       (ex_Jump),
      .mem_MemWrite  (mem_MemWrite),
      .mem_RGB       (mem_RGB),
      .wb_RegWrite   (wb_RegWrite),
      .wb_ResultSrc  (wb_ResultSrc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] t, input logic [1:0] o, input logic i);
      valid_in = v;
      tipo     = t;
      op       = o;
      Inm      = i;
   endtask

   task automatic all_zero(input string tag);
      check({tag, "_exsrc"}, 32'(ex_ALUSrc),     32'h0);
      check({tag, "_eximm"}, 32'(ex_ImmSrc),     32'h0);
      check({tag, "_exalu"}, 32'(ex_ALUControl), 32'h0);
      check({tag, "_exbr"},  32'(ex_Branch),     32'h0);
      check({tag, "_exjmp"}, 32'(ex_Jump),       32'h0);
      check({tag, "_memw"},  32'(mem_MemWrite),  32'h0);
      check({tag, "_rgb"},   32'(mem_RGB),       32'h0);
      check({tag, "_wbrw"},  32'(wb_RegWrite),   32'h0);
      check({tag, "_wbrs"},  32'(wb_ResultSrc),  32'h0);
   endtask

   initial begin
      // ---------------- 1: reset, then a DP instruction ----------------
      #1 rst = 1'b1;
      #1 all_zero("rst_async");
      tick();
      tick();
      rst = 1'b0;
      tick();
      all_zero("rst");
      check("rst_ready", 32'(ready_out), 32'h1);

      drive(1'b1, 2'b00, 2'b01, 1'b1);
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      check("dp_exalu", 32'(ex_ALUControl), 32'h1);
      check("dp_exsrc", 32'(ex_ALUSrc),     32'h1);
      check("dp_eximm", 32'(ex_ImmSrc),     32'h0);
      tick();
      check("dp_memw",  32'(mem_MemWrite),  32'h0);
      check("dp_wb_early", 32'(wb_RegWrite), 32'h0);
      tick();
      check("dp_wbrw",  32'(wb_RegWrite),   32'h1);
      check("dp_wbrs",  32'(wb_ResultSrc),  32'h0);
      tick();
      check("dp_wb_once", 32'(wb_RegWrite), 32'h0);

      // ---------------- decode of BR, JMP and a NOP encoding ----------------
      drive(1'b1, 2'b10, 2'b00, 1'b1);
      tick();
      check("br_exbr",  32'(ex_Branch),     32'h1);
      check("br_exalu", 32'(ex_ALUControl), 32'h1);
      check("br_eximm", 32'(ex_ImmSrc),     32'h2);
      drive(1'b1, 2'b11, 2'b00, 1'b1);
      tick();
      check("jmp_exjmp", 32'(ex_Jump),      32'h1);
      check("jmp_eximm", 32'(ex_ImmSrc),    32'h2);
      check("jmp_exsrc", 32'(ex_ALUSrc),    32'h0);
      drive(1'b1, 2'b11, 2'b01, 1'b1);
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      check("nop_exjmp", 32'(ex_Jump),      32'h0);
      check("nop_eximm", 32'(ex_ImmSrc),    32'h0);
      tick();
      tick();
      tick();

      // ---------------- 2: store burst ----------------
      drive(1'b1, 2'b01, 2'b11, 1'b0);
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      check("st_exsrc", 32'(ex_ALUSrc), 32'h1);
      check("st_eximm", 32'(ex_ImmSrc), 32'h1);
      tick();
      check("st_rgb0",   32'(mem_RGB),      32'h0);
      check("st_mw0",    32'(mem_MemWrite), 32'h1);
      check("st_rdy0",   32'(ready_out),    32'h0);
      tick();
      check("st_rgb1",   32'(mem_RGB),      32'h1);
      check("st_mw1",    32'(mem_MemWrite), 32'h1);
      check("st_rdy1",   32'(ready_out),    32'h0);
      tick();
      check("st_rgb2",   32'(mem_RGB),      32'h2);
      check("st_mw2",    32'(mem_MemWrite), 32'h1);
      check("st_rdy2",   32'(ready_out),    32'h1);
      tick();
      check("st_done_mw",  32'(mem_MemWrite), 32'h0);
      check("st_wb_norw",  32'(wb_RegWrite),  32'h0);

      // ---------------- 3: stall during beat 1 ----------------
      drive(1'b1, 2'b01, 2'b11, 1'b0);
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      tick();
      tick();
      check("stl_rgb1a", 32'(mem_RGB), 32'h1);
      stall_in = 1'b1;
      tick();
      check("stl_rgb1b", 32'(mem_RGB),   32'h1);
      check("stl_rdy",   32'(ready_out), 32'h0);
      tick();
      check("stl_rgb1c", 32'(mem_RGB),   32'h1);
      stall_in = 1'b0;
      tick();
      check("stl_rgb2",  32'(mem_RGB),      32'h2);
      check("stl_mw2",   32'(mem_MemWrite), 32'h1);
      tick();
      check("stl_done",  32'(mem_MemWrite), 32'h0);
      tick();

      // ---------------- 4: flush with a branch in EX ----------------
      drive(1'b1, 2'b01, 2'b00, 1'b0);
      tick();
      drive(1'b1, 2'b10, 2'b00, 1'b0);
      tick();
      check("fl_exbr",   32'(ex_Branch),    32'h1);
      check("fl_ld_rgb", 32'(mem_RGB),      32'h0);
      check("fl_ld_mw",  32'(mem_MemWrite), 32'h0);
      drive(1'b1, 2'b00, 2'b11, 1'b1);
      flush_in = 1'b1;
      tick();
      flush_in = 1'b0;
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      check("fl_exbr0",  32'(ex_Branch),     32'h0);
      check("fl_exsrc0", 32'(ex_ALUSrc),     32'h0);
      check("fl_exalu0", 32'(ex_ALUControl), 32'h0);
      check("fl_ld_wbrw", 32'(wb_RegWrite),  32'h1);
      check("fl_ld_wbrs", 32'(wb_ResultSrc), 32'h1);
      tick();
      tick();
      check("fl_no_dp_wb", 32'(wb_RegWrite), 32'h0);
      tick();

      // ---------------- 5: back-to-back load bursts ----------------
      drive(1'b1, 2'b01, 2'b10, 1'b0);
      tick();
      check("b2b_rdy", 32'(ready_out), 32'h1);
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      wb_pulses = 0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("b2b_rgb%0d", k), 32'(mem_RGB), 32'(k % 3));
         check($sformatf("b2b_mw%0d", k),  32'(mem_MemWrite), 32'h0);
         if (wb_RegWrite === 1'b1) wb_pulses++;
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         if (wb_RegWrite === 1'b1) wb_pulses++;
         tick();
      end
      check("b2b_wb_pulses", 32'(wb_pulses), 32'd2);

      // ---------------- 6: reset mid-burst ----------------
      drive(1'b1, 2'b01, 2'b10, 1'b0);
      tick();
      drive(1'b1, 2'b00, 2'b01, 1'b1);
      tick();
      drive(1'b0, 2'b00, 2'b00, 1'b0);
      tick();
      check("rb_rgb1", 32'(mem_RGB), 32'h1);
      #2 rst = 1'b1;
      #1 all_zero("rb_async");
      check("rb_rdy", 32'(ready_out), 32'h1);
      tick();
      rst = 1'b0;
      wb_pulses = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rb_rgb_post%0d", k), 32'(mem_RGB), 32'h0);
         if (wb_RegWrite === 1'b1) wb_pulses++;
      end
      check("rb_no_wb", 32'(wb_pulses), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_pipelined_control_unit
`default_nettype wire
